// File: rtl/freq_pkg.sv
// Shared types and constants for the frequency gate scheduler.
// Ranges: 0 = 1 s gate (x1), 1 = 100 ms gate (x10), 2 = 10 ms gate (x100).
// Range code 3 is folded onto range 2 everywhere.
package freq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_GATE,
    ST_CALC,
    ST_PUBLISH,
    ST_GUARD
  } state_t;

  typedef logic [1:0] range_t;

  localparam range_t RANGE_1S    = 2'd0;
  localparam range_t RANGE_100MS = 2'd1;
  localparam range_t RANGE_10MS  = 2'd2;

  localparam logic [6:0] MUL_1S    = 7'd1;
  localparam logic [6:0] MUL_100MS = 7'd10;
  localparam logic [6:0] MUL_10MS  = 7'd100;

  function automatic range_t range_clamp(input range_t r);
    return (r == 2'd3) ? RANGE_10MS : r;
  endfunction

  function automatic logic [6:0] range_mul(input range_t r);
    case (range_clamp(r))
      RANGE_1S:    return MUL_1S;
      RANGE_100MS: return MUL_100MS;
      default:     return MUL_10MS;
    endcase
  endfunction

  // Gate length in clk cycles for a range.
  function automatic logic [31:0] gate_len(input range_t r, input int unsigned clk_hz);
    case (range_clamp(r))
      RANGE_1S:    return clk_hz;
      RANGE_100MS: return clk_hz / 10;
      default:     return clk_hz / 100;
    endcase
  endfunction

endpackage

// File: rtl/freq_range_mul.sv
// Scales a gate edge count to Hz by the range factor (x1/x10/x100).
// The 39-bit product is clamped to 32 bits; sat flags the clamp.
module freq_range_mul import freq_pkg::*; (
  input  logic [31:0] count,
  input  logic [1:0]  rng,
  output logic [31:0] result,
  output logic        sat
);

  logic [38:0] product;

  // Wide product, then saturate to the 32-bit result.
  always_comb begin
    product = {7'd0, count} * {32'd0, range_mul(rng)};
    sat     = |product[38:32];
    result  = sat ? 32'hFFFF_FFFF : product[31:0];
  end

endmodule

// File: rtl/freq_gate_sched.sv
// Gate scheduler / auto-ranging controller for the frequency counter.
// Optional feature macro: FREQ_GATE_AUTORANGE_EN (auto-range compiled in).
// GUARD_CYC is expected to be at least 1.
//
// state      | meaning
// IDLE       | waiting for en
// ARM        | clear edge count, latch range, load gate timer
// GATE       | counting window, gate output high
// CALC       | scale count to Hz, register freq
// PUBLISH    | freq_valid high, auto-range step
// GUARD      | dead time between windows
module freq_gate_sched import freq_pkg::*; #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned GUARD_CYC = 1_000_000,
  parameter int unsigned HI_HZ     = 1_000_000,
  parameter int unsigned LO_HZ     = 500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        edge_rise,
  input  logic        range_auto,
  input  logic [1:0]  range_sel,
  output logic        gate,
  output logic        busy,
  output logic [31:0] freq,
  output logic        freq_valid,
  output logic [1:0]  range_cur,
  output logic        overflow
);

  state_t      state, state_nxt;
  logic [31:0] gate_cnt;
  logic [31:0] guard_cnt;
  logic [31:0] edge_cnt;
  logic [31:0] mul_result;
  logic        mul_sat;
  logic        auto_mode;
  range_t      arm_range;
  range_t      range_step;

`ifdef FREQ_GATE_AUTORANGE_EN
  localparam logic [31:0] HI_TH = HI_HZ;
  localparam logic [31:0] LO_TH = LO_HZ;

  assign auto_mode = range_auto;

  // One range step per published result, judged on the new freq.
  always_comb begin
    range_step = range_cur;
    if (freq >= HI_TH && range_cur < 2'd2)
      range_step = range_cur + 2'd1;
    else if (freq < LO_TH && range_cur > 2'd0)
      range_step = range_cur - 2'd1;
  end
`else
  logic unused_cfg;

  assign auto_mode  = 1'b0;
  assign range_step = range_cur;
  assign unused_cfg = range_auto ^ (HI_HZ > LO_HZ);
`endif

  // Range latched at ARM: forced selection, or the auto-range state.
  always_comb begin
    arm_range = range_cur;
    if (!auto_mode)
      arm_range = range_clamp(range_sel);
  end

  freq_range_mul u_mul (
    .count  (edge_cnt),
    .rng    (range_cur),
    .result (mul_result),
    .sat    (mul_sat)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and decoded outputs; en low aborts only in ARM/GATE.
  always_comb begin
    state_nxt = state;
    gate      = (state == ST_GATE);
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE:    if (en) state_nxt = ST_ARM;
      ST_ARM:     state_nxt = en ? ST_GATE : ST_IDLE;
      ST_GATE: begin
        if (!en)                 state_nxt = ST_IDLE;
        else if (gate_cnt == '0) state_nxt = ST_CALC;
      end
      ST_CALC:    state_nxt = ST_PUBLISH;
      ST_PUBLISH: state_nxt = ST_GUARD;
      ST_GUARD:   if (guard_cnt == '0) state_nxt = en ? ST_ARM : ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Timers, edge counter, result and range registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt   <= '0;
      guard_cnt  <= '0;
      edge_cnt   <= '0;
      freq       <= '0;
      freq_valid <= 1'b0;
      range_cur  <= RANGE_1S;
      overflow   <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      case (state)
        ST_ARM: begin
          edge_cnt <= '0;
          if (en) begin
            range_cur <= arm_range;
            gate_cnt  <= gate_len(arm_range, CLK_HZ) - 32'd1;
          end
        end
        ST_GATE: begin
          if (edge_rise && edge_cnt != 32'hFFFF_FFFF)
            edge_cnt <= edge_cnt + 32'd1;
          if (gate_cnt != '0)
            gate_cnt <= gate_cnt - 32'd1;
        end
        ST_CALC: begin
          freq       <= mul_result;
          freq_valid <= 1'b1;
          guard_cnt  <= GUARD_CYC - 32'd1;
          if (mul_sat)
            overflow <= 1'b1;
        end
        ST_PUBLISH: begin
          if (auto_mode)
            range_cur <= range_step;
        end
        ST_GUARD: begin
          if (guard_cnt != '0)
            guard_cnt <= guard_cnt - 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_gate_sched.sv
// Self-checking bench for freq_gate_sched (CLK_HZ=1000, GUARD_CYC=4,
// HI_HZ=300, LO_HZ=100). Expected results go into a scoreboard queue and
// are compared when freq_valid appears.
module tb_freq_gate_sched;

  localparam int unsigned CLK_HZ    = 1000;
  localparam int unsigned GUARD_CYC = 4;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        edge_rise;
  logic        range_auto;
  logic [1:0]  range_sel;
  logic        gate;
  logic        busy;
  logic [31:0] freq;
  logic        freq_valid;
  logic [1:0]  range_cur;
  logic        overflow;

  logic [31:0] mul_count;
  logic [1:0]  mul_rng;
  logic [31:0] mul_result;
  logic        mul_sat;

  int checks = 0;
  int errors = 0;
  int edge_period = 0;
  int edge_phase = 0;
  int gate_run = 0;
  int last_gate_len = 0;
  logic prev_valid = 1'b0;

  typedef struct {
    logic [31:0] f;
    logic [1:0]  r;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  freq_gate_sched #(
    .CLK_HZ    (CLK_HZ),
    .GUARD_CYC (GUARD_CYC),
    .HI_HZ     (300),
    .LO_HZ     (100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .edge_rise  (edge_rise),
    .range_auto (range_auto),
    .range_sel  (range_sel),
    .gate       (gate),
    .busy       (busy),
    .freq       (freq),
    .freq_valid (freq_valid),
    .range_cur  (range_cur),
    .overflow   (overflow)
  );

  freq_range_mul u_mul_chk (
    .count  (mul_count),
    .rng    (mul_rng),
    .result (mul_result),
    .sat    (mul_sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running edge stream: one pulse every edge_period cycles (0 = off).
  initial begin
    edge_rise = 1'b0;
    forever begin
      @(negedge clk);
      edge_phase++;
      edge_rise = (edge_period != 0) && (edge_phase % edge_period == 0);
    end
  end

  // Monitor: scoreboard compare on freq_valid, pulse width, gate length.
  always @(negedge clk) begin
    if (rst_n && freq_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: freq=%0d range=%0d, no result expected", freq, range_cur);
      end else begin
        mon_e = sb.pop_front();
        if (freq !== mon_e.f || range_cur !== mon_e.r) begin
          errors++;
          $display("FAIL result: freq=%0d range=%0d, expected freq=%0d range=%0d",
                   freq, range_cur, mon_e.f, mon_e.r);
        end
      end
      if (prev_valid) begin
        checks++;
        errors++;
        $display("FAIL valid_width: freq_valid high 2 cycles, expected 1");
      end
    end
    prev_valid = freq_valid;
    if (gate) gate_run++;
    else if (gate_run != 0) begin
      last_gate_len = gate_run;
      gate_run = 0;
    end
  end

  task automatic wait_valid(input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!freq_valid && cyc < max_cyc);
    if (!freq_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout_valid: no freq_valid within %0d cycles", max_cyc);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL timeout_idle: busy=%0d after %0d cycles, expected 0", busy, n);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0;
    range_auto = 1'b0;
    range_sel = 2'd0;
    mul_count = '0;
    mul_rng = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gate, busy, freq, freq_valid, range_cur, overflow} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: gate=%0d busy=%0d freq=%0d valid=%0d range=%0d ovf=%0d, expected all 0",
               gate, busy, freq, freq_valid, range_cur, overflow);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_forced_range0();
    int cyc;
    range_auto = 1'b0;
    range_sel = 2'd0;
    edge_period = 4;
    sb.push_back('{f: 32'd250, r: 2'd0});
    en = 1'b1;
    wait_valid(1100, cyc);
    en = 1'b0;
    checks++;
    if (cyc != CLK_HZ + 3) begin
      errors++;
      $display("FAIL latency_r0: valid after %0d cycles, expected %0d", cyc, CLK_HZ + 3);
    end
    checks++;
    if (last_gate_len != CLK_HZ) begin
      errors++;
      $display("FAIL gate_len_r0: gate high %0d cycles, expected %0d", last_gate_len, CLK_HZ);
    end
    wait_idle();
  endtask

  task automatic test_forced_sel3();
    int cyc;
    range_sel = 2'd3;
    edge_period = 2;
    sb.push_back('{f: 32'd500, r: 2'd2});
    en = 1'b1;
    wait_valid(100, cyc);
    en = 1'b0;
    checks++;
    if (last_gate_len != 10) begin
      errors++;
      $display("FAIL gate_len_sel3: gate high %0d cycles, expected 10", last_gate_len);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int cyc;
    range_sel = 2'd2;
    edge_period = 2;
    sb.push_back('{f: 32'd500, r: 2'd2});
    sb.push_back('{f: 32'd500, r: 2'd2});
    en = 1'b1;
    wait_valid(100, cyc);
    wait_valid(100, cyc);
    en = 1'b0;
    checks++;
    if (cyc != 10 + GUARD_CYC + 3) begin
      errors++;
      $display("FAIL period: valid spacing %0d cycles, expected %0d", cyc, 10 + GUARD_CYC + 3);
    end
    wait_idle();
  endtask

  task automatic test_abort();
    logic [31:0] freq_before;
    int n = 0;
    int seen = 0;
    freq_before = freq;
    range_sel = 2'd2;
    en = 1'b1;
    while (!gate && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (gate !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: gate=%0d busy=%0d, expected 0 0", gate, busy);
    end
    repeat (30) begin
      @(negedge clk);
      if (freq_valid) seen++;
    end
    checks++;
    if (seen != 0 || freq !== freq_before || range_cur !== 2'd2) begin
      errors++;
      $display("FAIL abort_hold: valids=%0d freq=%0d range=%0d, expected 0 %0d 2",
               seen, freq, range_cur, freq_before);
    end
  endtask

`ifdef FREQ_GATE_AUTORANGE_EN
  task automatic test_autorange();
    int cyc;
    pulse_reset();
    range_auto = 1'b1;
    range_sel = 2'd0;
    edge_period = 2;
    sb.push_back('{f: 32'd500, r: 2'd0});
    sb.push_back('{f: 32'd500, r: 2'd1});
    sb.push_back('{f: 32'd500, r: 2'd2});
    sb.push_back('{f: 32'd500, r: 2'd2});
    en = 1'b1;
    repeat (4) wait_valid(1100, cyc);
    edge_period = 0;
    sb.push_back('{f: 32'd0, r: 2'd2});
    sb.push_back('{f: 32'd0, r: 2'd1});
    sb.push_back('{f: 32'd0, r: 2'd0});
    repeat (3) wait_valid(1100, cyc);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (range_cur !== 2'd0) begin
      errors++;
      $display("FAIL auto_floor: range=%0d, expected 0", range_cur);
    end
    wait_idle();
    range_auto = 1'b0;
  endtask
`else
  task automatic test_auto_ignored();
    int cyc;
    range_auto = 1'b1;
    range_sel = 2'd1;
    edge_period = 2;
    sb.push_back('{f: 32'd500, r: 2'd1});
    sb.push_back('{f: 32'd500, r: 2'd1});
    en = 1'b1;
    repeat (2) wait_valid(200, cyc);
    en = 1'b0;
    wait_idle();
    checks++;
    if (range_cur !== 2'd1) begin
      errors++;
      $display("FAIL auto_ignored: range=%0d, expected 1", range_cur);
    end
    range_auto = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_gate();
    int cyc;
    int n = 0;
    range_sel = 2'd0;
    edge_period = 4;
    en = 1'b1;
    while (!gate && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gate, busy, freq, freq_valid, range_cur, overflow} !== 37'd0) begin
      errors++;
      $display("FAIL reset_mid_gate: gate=%0d busy=%0d freq=%0d valid=%0d range=%0d ovf=%0d, expected all 0",
               gate, busy, freq, freq_valid, range_cur, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{f: 32'd250, r: 2'd0});
    wait_valid(1100, cyc);
    en = 1'b0;
    checks++;
    if (cyc != CLK_HZ + 3) begin
      errors++;
      $display("FAIL restart_latency: valid after %0d cycles, expected %0d", cyc, CLK_HZ + 3);
    end
    wait_idle();
  endtask

  task automatic test_mul_sat();
    logic [31:0] cnts [7] = '{32'hFFFF_FFFF, 32'd429496730, 32'd429496729,
                              32'd42949673, 32'd42949672, 32'd5, 32'd0};
    logic [1:0]  rngs [7] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd2};
    logic [63:0] prod;
    logic [31:0] exp_res;
    logic        exp_sat;
    int          mult;
    for (int i = 0; i < 7; i++) begin
      mul_count = cnts[i];
      mul_rng = rngs[i];
      #1;
      mult = (rngs[i] == 2'd0) ? 1 : (rngs[i] == 2'd1) ? 10 : 100;
      prod = 64'(cnts[i]) * 64'(mult);
      exp_sat = (prod > 64'h0000_0000_FFFF_FFFF);
      exp_res = exp_sat ? 32'hFFFF_FFFF : prod[31:0];
      checks++;
      if (mul_result !== exp_res || mul_sat !== exp_sat) begin
        errors++;
        $display("FAIL mul_case%0d: result=%0d sat=%0d, expected %0d %0d",
                 i, mul_result, mul_sat, exp_res, exp_sat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forced_range0();
    test_forced_sel3();
    test_back_to_back();
    test_abort();
`ifdef FREQ_GATE_AUTORANGE_EN
    test_autorange();
`else
    test_auto_ignored();
`endif
    test_reset_mid_gate();
    test_mul_sat();
    checks++;
    if (overflow !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL final: overflow=%0d pending=%0d, expected 0 0", overflow, sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
